video_dram_arbiter: RTL and testbench

- Allocates 28 MHz DRAM cycles between the video fetch port, the CPU and refresh. Cycle boundaries are delimited by cend.
- Sits directly upstream of the video output top: consumes its video_go / video_bw / video_addr requests and returns video_next / video_strobe / video_data.
- Drives the DRAM controller's request interface.

---
 rtl/video_dram_arbiter_pkg.sv | 34 +++
 rtl/video_dram_rfsh_timer.sv | 66 ++++++
 rtl/video_dram_arbiter.sv | 197 +++++++++++++++++++
 tb/tb_video_dram_arbiter.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/video_dram_arbiter_pkg.sv
// Shared definitions for the video DRAM arbiter.
//   - cyc_e       : owner of the current DRAM cycle (IDLE / VIDEO / CPU / RFSH)
//   - DRAM_AW/DW  : DRAM word address and data widths
//   - Bw*         : video bandwidth encodings
//   - bw_to_mask  : bandwidth -> slot mask; a slot belongs to video when (slot & mask) == 0
package video_dram_arbiter_pkg;

    localparam int unsigned DRAM_AW = 21;
    localparam int unsigned DRAM_DW = 16;

    localparam logic [1:0] BwEighth  = 2'b00;
    localparam logic [1:0] BwQuarter = 2'b01;
    localparam logic [1:0] BwHalf    = 2'b10;
    localparam logic [1:0] BwFull    = 2'b11;

    typedef enum logic [1:0] {
        CycIdle  = 2'd0,
        CycVideo = 2'd1,
        CycCpu   = 2'd2,
        CycRfsh  = 2'd3
    } cyc_e;

    function automatic logic [2:0] bw_to_mask(input logic [1:0] bw);
        logic [2:0] mask;
        unique case (bw)
            BwEighth:  mask = 3'b111;
            BwQuarter: mask = 3'b011;
            BwHalf:    mask = 3'b001;
            BwFull:    mask = 3'b000;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/video_dram_rfsh_timer.sv
// Refresh scheduling for the video DRAM arbiter.
// Counts DRAM cycles (cend pulses); every RFSH_PERIOD cycles a refresh becomes pending.
// While pending, an age counter saturating at RFSH_FORCE tracks how long it has waited.
// Ports:
//   i_clk, i_rst_n     : clock, asynchronous active-low reset
//   i_cend             : last clk of a DRAM cycle
//   i_grant            : refresh granted at this cend
//   o_rfsh_pending     : a refresh is waiting
//   o_rfsh_urgent      : pending and aged to RFSH_FORCE, outranks the CPU
module video_dram_rfsh_timer #(
    parameter int unsigned RFSH_PERIOD = 64,
    parameter int unsigned RFSH_FORCE  = 16
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_cend,
    input  logic i_grant,
    output logic o_rfsh_pending,
    output logic o_rfsh_urgent
);

    localparam int unsigned CntW = (RFSH_PERIOD > 1) ? $clog2(RFSH_PERIOD) : 1;
    localparam int unsigned AgeW = (RFSH_FORCE > 0) ? $clog2(RFSH_FORCE + 1) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(RFSH_PERIOD - 1);
    localparam logic [AgeW-1:0] AgeMax  = AgeW'(RFSH_FORCE);

    logic [CntW-1:0] r_cnt;
    logic [AgeW-1:0] r_age;
    logic            r_pending;
    logic            w_wrap;

    assign w_wrap = i_cend && (r_cnt == CntLast);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_cend) begin
            r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;
        end
    end

    // A new request arriving on the same cend as a grant survives the grant.
    // A request while one is already pending is simply absorbed.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pending <= 1'b0;
            r_age     <= '0;
        end else if (i_cend) begin
            if (i_grant) begin
                r_pending <= w_wrap;
                r_age     <= '0;
            end else if (r_pending) begin
                if (r_age < AgeMax) begin
                    r_age <= r_age + 1'b1;
                end
            end else if (w_wrap) begin
                r_pending <= 1'b1;
                r_age     <= '0;
            end
        end
    end

    assign o_rfsh_pending = r_pending;
    assign o_rfsh_urgent  = r_pending && (r_age >= AgeMax);

endmodule

// File: rtl/video_dram_arbiter.sv
// DRAM cycle arbiter between video fetch, CPU and refresh.
// Each DRAM cycle ends with a one-clk cend pulse; the owner for the following cycle is
// decided on that clk and the DRAM request outputs are registered at the same edge.
// Read data returns at the cend closing the access and is registered to the requester.
// Ports:
//   i_clk, i_rst_n                       : 28 MHz clock, asynchronous active-low reset
//   i_cend, i_pre_cend                   : last clk / clk before last of a DRAM cycle
//   i_video_go, i_video_bw, i_video_addr : video fetch request side
//   o_video_next, o_video_strobe, o_video_data : video grant and returned word
//   i_cpu_req, i_cpu_rnw, i_cpu_addr, i_cpu_wrdata : CPU request side
//   o_cpu_next, o_cpu_strobe, o_cpu_rddata : CPU grant and read return
//   o_dram_req, o_dram_rnw, o_dram_rfsh, o_dram_addr, o_dram_wrdata : DRAM controller request
//   i_dram_rddata                        : DRAM read data, valid at cend of the access
module video_dram_arbiter
    import video_dram_arbiter_pkg::*;
#(
    parameter int unsigned RFSH_PERIOD = 64,
    parameter int unsigned RFSH_FORCE  = 16
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_cend,
    input  logic               i_pre_cend,
    input  logic               i_video_go,
    input  logic [1:0]         i_video_bw,
    input  logic [DRAM_AW-1:0] i_video_addr,
    output logic               o_video_next,
    output logic               o_video_strobe,
    output logic [DRAM_DW-1:0] o_video_data,
    input  logic               i_cpu_req,
    input  logic               i_cpu_rnw,
    input  logic [DRAM_AW-1:0] i_cpu_addr,
    input  logic [DRAM_DW-1:0] i_cpu_wrdata,
    output logic               o_cpu_next,
    output logic               o_cpu_strobe,
    output logic [DRAM_DW-1:0] o_cpu_rddata,
    output logic               o_dram_req,
    output logic               o_dram_rnw,
    output logic               o_dram_rfsh,
    output logic [DRAM_AW-1:0] o_dram_addr,
    output logic [DRAM_DW-1:0] o_dram_wrdata,
    input  logic [DRAM_DW-1:0] i_dram_rddata
);

    cyc_e               r_cyc;
    cyc_e               w_cyc_d;
    logic [2:0]         r_slot;
    logic [2:0]         r_mask;
    logic               w_video_slot;
    logic               w_video_grant;
    logic               w_cpu_grant;
    logic               w_rfsh_grant;
    logic               w_rfsh_pending;
    logic               w_rfsh_urgent;

    logic               r_video_strobe;
    logic [DRAM_DW-1:0] r_video_data;
    logic               r_cpu_strobe;
    logic [DRAM_DW-1:0] r_cpu_rddata;
    logic               r_dram_req;
    logic               r_dram_rnw;
    logic               r_dram_rfsh;
    logic [DRAM_AW-1:0] r_dram_addr;
    logic [DRAM_DW-1:0] r_dram_wrdata;

    video_dram_rfsh_timer #(
        .RFSH_PERIOD (RFSH_PERIOD),
        .RFSH_FORCE  (RFSH_FORCE)
    ) u_rfsh_timer (
        .i_clk          (i_clk),
        .i_rst_n        (i_rst_n),
        .i_cend         (i_cend),
        .i_grant        (w_rfsh_grant),
        .o_rfsh_pending (w_rfsh_pending),
        .o_rfsh_urgent  (w_rfsh_urgent)
    );

    // Mask is captured one clk early so the slot compare at cend is a short path.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_mask <= bw_to_mask(BwEighth);
        end else if (i_pre_cend) begin
            r_mask <= bw_to_mask(i_video_bw);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_slot <= 3'd0;
        end else if (i_cend) begin
            r_slot <= i_video_go ? r_slot + 3'd1 : 3'd0;
        end
    end

    assign w_video_slot = i_video_go && ((r_slot & r_mask) == 3'b000);

    // Cycle-owner FSM: state register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cyc <= CycIdle;
        end else begin
            r_cyc <= w_cyc_d;
        end
    end

    // Cycle-owner FSM: arbitration at cend
    always_comb begin
        w_cyc_d       = r_cyc;
        w_video_grant = 1'b0;
        w_cpu_grant   = 1'b0;
        w_rfsh_grant  = 1'b0;
        if (i_cend) begin
            if (w_video_slot) begin
                w_cyc_d = CycVideo;
            end else if (w_rfsh_urgent) begin
                w_cyc_d = CycRfsh;
            end else if (i_cpu_req) begin
                w_cyc_d = CycCpu;
            end else if (w_rfsh_pending) begin
                w_cyc_d = CycRfsh;
            end else begin
                w_cyc_d = CycIdle;
            end
            w_video_grant = (w_cyc_d == CycVideo);
            w_cpu_grant   = (w_cyc_d == CycCpu);
            w_rfsh_grant  = (w_cyc_d == CycRfsh);
        end
    end

    // Grants are combinational; gating with reset keeps every output low while held in reset.
    assign o_video_next = w_video_grant && i_rst_n;
    assign o_cpu_next   = w_cpu_grant && i_rst_n;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_dram_req    <= 1'b0;
            r_dram_rnw    <= 1'b0;
            r_dram_rfsh   <= 1'b0;
            r_dram_addr   <= '0;
            r_dram_wrdata <= '0;
        end else if (i_cend) begin
            unique case (w_cyc_d)
                CycVideo: begin
                    r_dram_req  <= 1'b1;
                    r_dram_rnw  <= 1'b1;
                    r_dram_rfsh <= 1'b0;
                    r_dram_addr <= i_video_addr;
                end
                CycCpu: begin
                    r_dram_req    <= 1'b1;
                    r_dram_rnw    <= i_cpu_rnw;
                    r_dram_rfsh   <= 1'b0;
                    r_dram_addr   <= i_cpu_addr;
                    r_dram_wrdata <= i_cpu_wrdata;
                end
                CycRfsh: begin
                    r_dram_req  <= 1'b0;
                    r_dram_rfsh <= 1'b1;
                end
                CycIdle: begin
                    r_dram_req  <= 1'b0;
                    r_dram_rfsh <= 1'b0;
                end
            endcase
        end
    end

    // Return path: r_cyc and r_dram_rnw still describe the cycle closing at this cend.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_video_strobe <= 1'b0;
            r_video_data   <= '0;
            r_cpu_strobe   <= 1'b0;
            r_cpu_rddata   <= '0;
        end else begin
            r_video_strobe <= i_cend && (r_cyc == CycVideo);
            r_cpu_strobe   <= i_cend && (r_cyc == CycCpu) && r_dram_rnw;
            if (i_cend && (r_cyc == CycVideo)) begin
                r_video_data <= i_dram_rddata;
            end
            if (i_cend && (r_cyc == CycCpu) && r_dram_rnw) begin
                r_cpu_rddata <= i_dram_rddata;
            end
        end
    end

    assign o_video_strobe = r_video_strobe;
    assign o_video_data   = r_video_data;
    assign o_cpu_strobe   = r_cpu_strobe;
    assign o_cpu_rddata   = r_cpu_rddata;
    assign o_dram_req     = r_dram_req;
    assign o_dram_rnw     = r_dram_rnw;
    assign o_dram_rfsh    = r_dram_rfsh;
    assign o_dram_addr    = r_dram_addr;
    assign o_dram_wrdata  = r_dram_wrdata;

endmodule

// File: tb/tb_video_dram_arbiter.sv
// Self-checking bench for video_dram_arbiter: directed phases followed by random traffic,
// checked every clk against a DRAM-cycle-level reference model.
module tb_video_dram_arbiter;

    localparam int P = 8;   // refresh period
    localparam int F = 2;   // refresh force age
    localparam int TI = 0, TV = 1, TC = 2, TR = 3;

    logic        i_clk, i_rst_n, i_cend, i_pre_cend;
    logic        i_video_go;
    logic [1:0]  i_video_bw;
    logic [20:0] i_video_addr;
    logic        o_video_next, o_video_strobe;
    logic [15:0] o_video_data;
    logic        i_cpu_req, i_cpu_rnw;
    logic [20:0] i_cpu_addr;
    logic [15:0] i_cpu_wrdata;
    logic        o_cpu_next, o_cpu_strobe;
    logic [15:0] o_cpu_rddata;
    logic        o_dram_req, o_dram_rnw, o_dram_rfsh;
    logic [20:0] o_dram_addr;
    logic [15:0] o_dram_wrdata;
    logic [15:0] i_dram_rddata;

    video_dram_arbiter #(
        .RFSH_PERIOD (P),
        .RFSH_FORCE  (F)
    ) dut (
        .i_clk          (i_clk),
        .i_rst_n        (i_rst_n),
        .i_cend         (i_cend),
        .i_pre_cend     (i_pre_cend),
        .i_video_go     (i_video_go),
        .i_video_bw     (i_video_bw),
        .i_video_addr   (i_video_addr),
        .o_video_next   (o_video_next),
        .o_video_strobe (o_video_strobe),
        .o_video_data   (o_video_data),
        .i_cpu_req      (i_cpu_req),
        .i_cpu_rnw      (i_cpu_rnw),
        .i_cpu_addr     (i_cpu_addr),
        .i_cpu_wrdata   (i_cpu_wrdata),
        .o_cpu_next     (o_cpu_next),
        .o_cpu_strobe   (o_cpu_strobe),
        .o_cpu_rddata   (o_cpu_rddata),
        .o_dram_req     (o_dram_req),
        .o_dram_rnw     (o_dram_rnw),
        .o_dram_rfsh    (o_dram_rfsh),
        .o_dram_addr    (o_dram_addr),
        .o_dram_wrdata  (o_dram_wrdata),
        .i_dram_rddata  (i_dram_rddata)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // DRAM contents: a fixed scramble of the address.
    function automatic logic [15:0] mem_word(input logic [20:0] a);
        return a[15:0] ^ {a[20:16], 11'h2B5} ^ 16'h9E37;
    endfunction

    assign i_dram_rddata = mem_word(o_dram_addr);

    int total = 0;
    int bad = 0;
    int n_vnext = 0, n_cnext = 0, n_rfsh = 0;

    // Reference model state (per DRAM cycle)
    int          m_slot, m_cnt, m_age, m_cur;
    bit          m_pend, m_cur_rnw;
    logic [20:0] m_cur_addr;
    logic        e_vstb, e_cstb, e_req, e_rnw, e_rfsh;
    logic [15:0] e_vdata, e_cdata, e_wd;
    logic [20:0] e_addr;
    logic [20:0] g_vaddr, g_caddr;
    logic [15:0] g_wd;
    bit          g_rnw, g_go;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_slot = 0; m_cnt = 0; m_age = 0; m_pend = 0; m_cur = TI;
        m_cur_rnw = 0; m_cur_addr = '0;
        e_vstb = 0; e_cstb = 0; e_req = 0; e_rnw = 0; e_rfsh = 0;
        e_vdata = '0; e_cdata = '0; e_wd = '0; e_addr = '0;
    endtask

    // Owner of the next cycle, from the priority rules.
    function automatic int decide();
        int per;
        per = 8 >> i_video_bw;   // video gets one slot in every 'per'
        if (i_video_go && (m_slot % per) == 0) return TV;
        if (m_pend && m_age >= F) return TR;
        if (i_cpu_req) return TC;
        if (m_pend) return TR;
        return TI;
    endfunction

    task automatic model_cend(input int g);
        if (m_cur == TV) begin
            e_vstb = 1; e_vdata = mem_word(m_cur_addr);
        end
        if (m_cur == TC && m_cur_rnw) begin
            e_cstb = 1; e_cdata = mem_word(m_cur_addr);
        end
        case (g)
            TV: begin
                e_req = 1; e_rnw = 1; e_rfsh = 0; e_addr = g_vaddr;
                m_cur_addr = g_vaddr; m_cur_rnw = 1;
            end
            TC: begin
                e_req = 1; e_rnw = g_rnw; e_rfsh = 0; e_addr = g_caddr; e_wd = g_wd;
                m_cur_addr = g_caddr; m_cur_rnw = g_rnw;
            end
            TR: begin e_req = 0; e_rfsh = 1; end
            default: begin e_req = 0; e_rfsh = 0; end
        endcase
        m_cur = g;
        if (g == TR) begin
            m_pend = 0; m_age = 0;
        end else if (m_pend && m_age < F) begin
            m_age++;
        end
        m_cnt++;
        if (m_cnt == P) begin
            m_cnt = 0;
            if (!m_pend) begin m_pend = 1; m_age = 0; end
        end
        m_slot = g_go ? (m_slot + 1) % 8 : 0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_vnext"}, o_video_next, 0);
        chk({tag, "_vstb"}, o_video_strobe, 0);
        chk({tag, "_vdata"}, o_video_data, 0);
        chk({tag, "_cnext"}, o_cpu_next, 0);
        chk({tag, "_cstb"}, o_cpu_strobe, 0);
        chk({tag, "_cdata"}, o_cpu_rddata, 0);
        chk({tag, "_req"}, o_dram_req, 0);
        chk({tag, "_rnw"}, o_dram_rnw, 0);
        chk({tag, "_rfsh"}, o_dram_rfsh, 0);
        chk({tag, "_addr"}, o_dram_addr, 0);
        chk({tag, "_wd"}, o_dram_wrdata, 0);
    endtask

    // One clk: entered and left at posedge+1.
    task automatic clk_step(input bit c, input bit p);
        int g;
        i_cend = c; i_pre_cend = p;
        i_video_addr = 21'($urandom);
        g = c ? decide() : TI;
        g_vaddr = i_video_addr; g_caddr = i_cpu_addr; g_wd = i_cpu_wrdata;
        g_rnw = i_cpu_rnw; g_go = i_video_go;
        #1;
        chk("video_next", o_video_next, (c && g == TV) ? 1 : 0);
        chk("cpu_next", o_cpu_next, (c && g == TC) ? 1 : 0);
        if (o_video_next) n_vnext++;
        if (o_cpu_next) n_cnext++;
        @(posedge i_clk); #1;
        e_vstb = 0; e_cstb = 0;
        if (c) model_cend(g);
        if (c && o_dram_rfsh) n_rfsh++;
        chk("video_strobe", o_video_strobe, e_vstb);
        chk("video_data", o_video_data, e_vdata);
        chk("cpu_strobe", o_cpu_strobe, e_cstb);
        chk("cpu_rddata", o_cpu_rddata, e_cdata);
        chk("dram_req", o_dram_req, e_req);
        chk("dram_rnw", o_dram_rnw, e_rnw);
        chk("dram_rfsh", o_dram_rfsh, e_rfsh);
        chk("dram_addr", o_dram_addr, e_addr);
        chk("dram_wrdata", o_dram_wrdata, e_wd);
    endtask

    task automatic dram_cycle();
        clk_step(0, 0);
        clk_step(0, 0);
        clk_step(0, 1);
        clk_step(1, 0);
    endtask

    task automatic set_req(input bit go, input logic [1:0] bw, input bit creq, input bit rnw,
                           input logic [20:0] caddr, input logic [15:0] cwd);
        i_video_go = go; i_video_bw = bw; i_cpu_req = creq; i_cpu_rnw = rnw;
        i_cpu_addr = caddr; i_cpu_wrdata = cwd;
    endtask

    initial begin
        int bv, bc, br, k;
        i_rst_n = 0; i_cend = 0; i_pre_cend = 0; i_video_addr = '0;
        set_req(0, 2'b00, 0, 0, '0, '0);
        model_reset();
        #1;
        chk_all_zero("reset");
        repeat (2) @(posedge i_clk);
        #1;
        i_rst_n = 1;

        // Bandwidth 1/8, no CPU: 2 video grants in 16 cycles
        set_req(1, 2'b00, 0, 0, '0, '0);
        bv = n_vnext;
        repeat (16) dram_cycle();
        chk("bw8_vnext_count", n_vnext - bv, 2);

        // Bandwidth 1/4 with CPU held: 2 video, rest CPU or refresh
        set_req(0, 2'b01, 0, 0, '0, '0);
        dram_cycle();
        set_req(1, 2'b01, 1, 1, 21'h00123, 16'h0);
        bv = n_vnext; bc = n_cnext; br = n_rfsh;
        repeat (8) dram_cycle();
        chk("bw4_vnext_count", n_vnext - bv, 2);
        chk("bw4_other_count", (n_cnext - bc) + (n_rfsh - br), 6);

        // Refresh escalation under continuous CPU load
        set_req(0, 2'b00, 1, 1, 21'h00456, 16'h0);
        br = n_rfsh;
        repeat (12) dram_cycle();
        chk("rfsh_under_cpu_load", (n_rfsh > br) ? 1 : 0, 1);

        // CPU write then read of the same address
        set_req(0, 2'b00, 1, 0, 21'h1ABCD, 16'h55AA);
        bc = n_cnext; k = 0;
        while (n_cnext == bc && k < 4) begin dram_cycle(); k++; end
        chk("cpu_write_grant", (n_cnext > bc) ? 1 : 0, 1);
        chk("cpu_write_data", o_dram_wrdata, 16'h55AA);
        set_req(0, 2'b00, 1, 1, 21'h1ABCD, 16'h0);
        bc = n_cnext; k = 0;
        while (n_cnext == bc && k < 4) begin dram_cycle(); k++; end
        chk("cpu_read_grant", (n_cnext > bc) ? 1 : 0, 1);
        set_req(0, 2'b00, 0, 0, '0, '0);
        dram_cycle();

        // video_go drop after a VIDEO grant
        set_req(1, 2'b00, 0, 0, '0, '0);
        bv = n_vnext; k = 0;
        while (n_vnext == bv && k < 9) begin dram_cycle(); k++; end
        chk("vgo_first_grant", (n_vnext > bv) ? 1 : 0, 1);
        set_req(0, 2'b00, 0, 0, '0, '0);
        bv = n_vnext;
        repeat (3) dram_cycle();
        chk("vgo_drop_no_vnext", n_vnext - bv, 0);
        set_req(1, 2'b00, 0, 0, '0, '0);
        bv = n_vnext;
        dram_cycle();
        chk("vgo_restart_slot0", n_vnext - bv, 1);

        // Reset in the middle of a VIDEO cycle
        set_req(1, 2'b11, 0, 0, '0, '0);
        dram_cycle();
        clk_step(0, 0);
        i_rst_n = 0;
        #1;
        chk_all_zero("midreset");
        model_reset();
        repeat (2) @(posedge i_clk);
        #1;
        i_rst_n = 1;
        set_req(1, 2'b00, 0, 0, '0, '0);
        bv = n_vnext;
        dram_cycle();
        chk("post_reset_slot0", n_vnext - bv, 1);
        dram_cycle();

        // Random traffic
        for (int i = 0; i < 150; i++) begin
            set_req(($urandom % 4) != 0, 2'($urandom), 1'($urandom), 1'($urandom),
                    21'($urandom), 16'($urandom));
            dram_cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
